// File: rtl/axi_sram_pkg.sv
// axi_sram_pkg: types and constants shared by the AXI-to-SRAM read and write channels.
package axi_sram_pkg;

  // Width of the SRAM byte address.
  localparam int SRAM_AW = 16;

  // AXI response codes used by the bridge.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // AXI burst types (2'b11 is reserved and never stored).
  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  // Read FSM: issue SRAM read, wait one cycle for data, present beat.
  typedef enum logic [1:0] {
    RD_IDLE = 2'b00,
    RD_RD   = 2'b01,
    RD_WAIT = 2'b10,
    RD_DATA = 2'b11
  } rd_state_e;

  // Byte step per beat; sizes wider than the 32-bit SRAM word step by 4.
  function automatic logic [SRAM_AW-1:0] addr_step(input logic [2:0] size);
    case (size)
      3'd0:    return 16'd1;
      3'd1:    return 16'd2;
      default: return 16'd4;
    endcase
  endfunction

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_r_channel_if.sv
// axi_r_channel_if: AXI read-address and read-data channel signals.
interface axi_r_channel_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [7:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  ARREADY, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output ARREADY, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi_addr_gen.sv
// axi_addr_gen: next beat address for FIXED / INCR / WRAP bursts (16-bit, wraps mod 2^16).
module axi_addr_gen
  import axi_sram_pkg::*;
(
  input  logic [SRAM_AW-1:0] addr_i,
  input  logic [2:0]         size_i,
  input  burst_e             burst_i,
  input  logic [7:0]         len_i,
  output logic [SRAM_AW-1:0] next_addr_o
);
  logic [SRAM_AW-1:0] step;
  logic [SRAM_AW-1:0] incr_addr;
  logic [SRAM_AW-1:0] wrap_mask;

  // Compute step, incremented address and wrap boundary, then select by burst type.
  always_comb begin
    step        = addr_step(size_i);
    incr_addr   = addr_i + step;
    // Block size is (len+1)*step, a power of two for legal WRAP lengths.
    wrap_mask   = (({{(SRAM_AW-8){1'b0}}, len_i} + 16'd1) * step) - 16'd1;
    next_addr_o = incr_addr;
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr_o = incr_addr;
    endcase
  end
endmodule

// File: rtl/axi_r_channel.sv
// axi_r_channel: AXI read channel bridging to a 32-bit SRAM with one-cycle read latency.
// Optional feature: define AXI_R_CHANNEL_WRAP_EN to support WRAP bursts; otherwise WRAP acts as INCR.
module axi_r_channel
  import axi_sram_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  axi_r_channel_if.slave     axi,
  output logic               ren,
  output logic [SRAM_AW-1:0] araddr,
  output logic [2:0]         arsize,
  input  logic [31:0]        rdata
);
  rd_state_e              state_q, state_d;
  logic                   arready_q, arready_d;
  logic [SRAM_AW-1:0]     addr_q, addr_d;
  logic [7:0]             len_q, len_d;
  logic [2:0]             size_q, size_d;
  burst_e                 burst_q, burst_d;
  logic                   err_q, err_d;
  logic [7:0]             beat_q, beat_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   rvalid_q, rvalid_d;
  logic                   rlast_q, rlast_d;
  logic [1:0]             rresp_q, rresp_d;

  logic                   ar_err;
  burst_e                 ar_burst;
  logic [SRAM_AW-1:0]     next_addr;
  logic                   unused_araddr_hi;

  // Only the low SRAM_AW address bits reach the SRAM.
  assign unused_araddr_hi = ^axi.ARADDR[ADDR_WIDTH-1:SRAM_AW];

  axi_addr_gen u_addr_gen (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .burst_i     (burst_q),
    .len_i       (len_q),
    .next_addr_o (next_addr)
  );

  // Classify the incoming request: error bursts always run as INCR.
  always_comb begin
    ar_err   = (axi.ARSIZE > 3'd2) || (axi.ARBURST == 2'b11);
    ar_burst = BURST_INCR;
    case (axi.ARBURST)
      2'b00: ar_burst = BURST_FIXED;
      2'b10: begin
`ifdef AXI_R_CHANNEL_WRAP_EN
        if (!wrap_len_ok(axi.ARLEN)) ar_err = 1'b1;
        else                         ar_burst = BURST_WRAP;
`else
        ar_burst = BURST_INCR;
`endif
      end
      default: ar_burst = BURST_INCR;
    endcase
    if (ar_err) ar_burst = BURST_INCR;
  end

  // State and datapath registers; reset abandons any burst in flight.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= RD_IDLE;
      arready_q <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= BURST_FIXED;
      err_q     <= 1'b0;
      beat_q    <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      err_q     <= err_d;
      beat_q    <= beat_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
    end
  end

  // Next-state and datapath updates for the IDLE -> RD -> WAIT -> DATA sequence.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    size_d   = size_q;
    burst_d  = burst_q;
    err_d    = err_q;
    beat_d   = beat_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
    rresp_d  = rresp_q;
    case (state_q)
      RD_IDLE: begin
        if (axi.ARVALID && arready_q) begin
          addr_d  = axi.ARADDR[SRAM_AW-1:0];
          len_d   = axi.ARLEN;
          size_d  = axi.ARSIZE;
          burst_d = ar_burst;
          err_d   = ar_err;
          beat_d  = '0;
          state_d = RD_RD;
        end
      end
      RD_RD: state_d = RD_WAIT;
      RD_WAIT: begin
        // SRAM data is valid now, one cycle after the read strobe.
        rdata_d = '0;
        case (size_q)
          3'd0:    rdata_d[7:0]  = rdata[7:0];
          3'd1:    rdata_d[15:0] = rdata[15:0];
          default: rdata_d[31:0] = rdata;
        endcase
        rvalid_d = 1'b1;
        rlast_d  = (beat_q == len_q);
        rresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
        state_d  = RD_DATA;
      end
      RD_DATA: begin
        if (axi.RREADY) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          if (rlast_q) begin
            state_d = RD_IDLE;
          end else begin
            beat_d  = beat_q + 8'd1;
            addr_d  = next_addr;
            state_d = RD_RD;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
    // Registered so that ARREADY stays low until the first edge after reset.
    arready_d = (state_d == RD_IDLE);
  end

  assign ren         = (state_q == RD_RD);
  assign araddr      = addr_q;
  assign arsize      = size_q;
  assign axi.ARREADY = arready_q;
  assign axi.RDATA   = rdata_q;
  assign axi.RRESP   = rresp_q;
  assign axi.RLAST   = rlast_q;
  assign axi.RVALID  = rvalid_q;
endmodule

// File: tb/tb_axi_r_channel.sv
// tb_axi_r_channel: directed bursts against axi_r_channel with a one-cycle-latency SRAM model.
// Expected addresses for WRAP depend on AXI_R_CHANNEL_WRAP_EN, matching the build of the design.
module tb_axi_r_channel;
  import axi_sram_pkg::*;

  localparam int DW = 64;
  localparam int AW = 32;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        ren;
  logic [15:0] araddr;
  logic [2:0]  arsize;
  logic [31:0] rdata;
  logic        sram_fixed;
  logic [15:0] ea [16];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 ACLK = ~ACLK;

  axi_r_channel_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axi ();

  axi_r_channel #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .axi     (axi),
    .ren     (ren),
    .araddr  (araddr),
    .arsize  (arsize),
    .rdata   (rdata)
  );

  // SRAM model: data appears the cycle after the read strobe.
  always @(posedge ACLK) begin
    if (ren) rdata <= sram_fixed ? 32'hAABBCCDD : {16'hA5A5, araddr};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [63:0] exp_rdata(input logic [15:0] a, input logic [2:0] sz,
                                            input logic fixed);
    logic [31:0] w;
    w = fixed ? 32'hAABBCCDD : {16'hA5A5, a};
    case (sz)
      3'd0:    return {56'd0, w[7:0]};
      3'd1:    return {48'd0, w[15:0]};
      default: return {32'd0, w};
    endcase
  endfunction

  // One AR request followed by every beat; ea[] holds the expected SRAM addresses.
  task automatic run_burst(input string name, input logic [15:0] start, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [1:0] exp_resp, input int stall_beat);
    logic [63:0] ed;
    check({name, ":arready_idle"}, 64'(axi.ARREADY), 64'd1);
    axi.ARADDR  = {16'h1234, start};
    axi.ARLEN   = len;
    axi.ARSIZE  = size;
    axi.ARBURST = burst;
    axi.ARVALID = 1'b1;
    tick();
    axi.ARVALID = 1'b0;
    check({name, ":arready_busy"}, 64'(axi.ARREADY), 64'd0);
    for (int b = 0; b <= int'(len); b++) begin
      check({name, ":ren_rd"}, 64'(ren), 64'd1);
      check({name, ":araddr"}, 64'(araddr), 64'(ea[b]));
      check({name, ":arsize"}, 64'(arsize), 64'(size));
      check({name, ":rvalid_rd"}, 64'(axi.RVALID), 64'd0);
      tick();
      check({name, ":ren_wait"}, 64'(ren), 64'd0);
      check({name, ":rvalid_wait"}, 64'(axi.RVALID), 64'd0);
      tick();
      ed = exp_rdata(ea[b], size, sram_fixed);
      check({name, ":rvalid_data"}, 64'(axi.RVALID), 64'd1);
      check({name, ":rdata"}, axi.RDATA, ed);
      check({name, ":rresp"}, 64'(axi.RRESP), 64'(exp_resp));
      check({name, ":rlast"}, 64'(axi.RLAST), 64'(b == int'(len)));
      $display("[TB] %s beat %0d araddr=%h rdata=%h rresp=%0d rlast=%0d",
               name, b, araddr, axi.RDATA, axi.RRESP, axi.RLAST);
      if (b == stall_beat) begin
        axi.RREADY = 1'b0;
        for (int s = 0; s < 5; s++) begin
          axi.ARVALID = (s == 1);
          tick();
          check({name, ":stall_rvalid"}, 64'(axi.RVALID), 64'd1);
          check({name, ":stall_rdata"}, axi.RDATA, ed);
          check({name, ":stall_rlast"}, 64'(axi.RLAST), 64'(b == int'(len)));
          check({name, ":stall_ren"}, 64'(ren), 64'd0);
          check({name, ":stall_arready"}, 64'(axi.ARREADY), 64'd0);
        end
        axi.ARVALID = 1'b0;
        axi.RREADY  = 1'b1;
      end
      tick();
    end
    check({name, ":rvalid_end"}, 64'(axi.RVALID), 64'd0);
    check({name, ":rlast_end"}, 64'(axi.RLAST), 64'd0);
    check({name, ":ren_end"}, 64'(ren), 64'd0);
  endtask

  initial begin
    ARESETn     = 1'b0;
    axi.ARADDR  = '0;
    axi.ARLEN   = '0;
    axi.ARSIZE  = '0;
    axi.ARBURST = '0;
    axi.ARVALID = 1'b0;
    axi.RREADY  = 1'b1;
    sram_fixed  = 1'b0;
    rdata       = '0;
    repeat (3) tick();

    // Reset values
    check("rst:arready", 64'(axi.ARREADY), 64'd0);
    check("rst:rvalid", 64'(axi.RVALID), 64'd0);
    check("rst:rlast", 64'(axi.RLAST), 64'd0);
    check("rst:rresp", 64'(axi.RRESP), 64'd0);
    check("rst:rdata", axi.RDATA, 64'd0);
    check("rst:ren", 64'(ren), 64'd0);
    check("rst:araddr", 64'(araddr), 64'd0);
    check("rst:arsize", 64'(arsize), 64'd0);
    ARESETn = 1'b1;
    #1;
    check("rel:arready_before_edge", 64'(axi.ARREADY), 64'd0);
    tick();
    check("rel:arready_after_edge", 64'(axi.ARREADY), 64'd1);

    // INCR, 4 words
    ea[0] = 16'h0010; ea[1] = 16'h0014; ea[2] = 16'h0018; ea[3] = 16'h001C;
    run_burst("incr4", 16'h0010, 8'd3, 3'd2, 2'b01, RESP_OKAY, -1);

    // FIXED bytes from a constant SRAM word
    sram_fixed = 1'b1;
    ea[0] = 16'h0040; ea[1] = 16'h0040; ea[2] = 16'h0040;
    run_burst("fixed", 16'h0040, 8'd2, 3'd0, 2'b00, RESP_OKAY, -1);
    sram_fixed = 1'b0;

    // INCR across the 16-bit address boundary
    ea[0] = 16'hFFFE; ea[1] = 16'h0000;
    run_burst("incr_wrap16", 16'hFFFE, 8'd1, 3'd1, 2'b01, RESP_OKAY, -1);

    // Back-pressure on beat 2 with an ARVALID pulse that must be ignored
    ea[0] = 16'h0100; ea[1] = 16'h0104; ea[2] = 16'h0108;
    run_burst("stall", 16'h0100, 8'd2, 3'd2, 2'b01, RESP_OKAY, 1);

    // WRAP burst
`ifdef AXI_R_CHANNEL_WRAP_EN
    ea[0] = 16'h0038; ea[1] = 16'h003C; ea[2] = 16'h0030; ea[3] = 16'h0034;
`else
    ea[0] = 16'h0038; ea[1] = 16'h003C; ea[2] = 16'h0040; ea[3] = 16'h0044;
`endif
    run_burst("wrap4", 16'h0038, 8'd3, 3'd2, 2'b10, RESP_OKAY, -1);

    // WRAP with an illegal length
    ea[0] = 16'h0050; ea[1] = 16'h0054; ea[2] = 16'h0058;
`ifdef AXI_R_CHANNEL_WRAP_EN
    run_burst("wrap_badlen", 16'h0050, 8'd2, 3'd2, 2'b10, RESP_SLVERR, -1);
`else
    run_burst("wrap_badlen", 16'h0050, 8'd2, 3'd2, 2'b10, RESP_OKAY, -1);
`endif

    // Oversized ARSIZE, single beat
    ea[0] = 16'h0200;
    run_burst("size3", 16'h0200, 8'd0, 3'd3, 2'b01, RESP_SLVERR, -1);

    // Reserved burst type runs as INCR with SLVERR
    ea[0] = 16'h0300; ea[1] = 16'h0301;
    run_burst("burst11", 16'h0300, 8'd1, 3'd0, 2'b11, RESP_SLVERR, -1);

    // Reset asserted while a beat is presented
    axi.ARADDR  = 32'h0000_0010;
    axi.ARLEN   = 8'd3;
    axi.ARSIZE  = 3'd2;
    axi.ARBURST = 2'b01;
    axi.ARVALID = 1'b1;
    tick();
    axi.ARVALID = 1'b0;
    tick();
    tick();
    check("midrst:rvalid_before", 64'(axi.RVALID), 64'd1);
    #2;
    ARESETn = 1'b0;
    #1;
    check("midrst:rvalid", 64'(axi.RVALID), 64'd0);
    check("midrst:rlast", 64'(axi.RLAST), 64'd0);
    check("midrst:ren", 64'(ren), 64'd0);
    check("midrst:arready", 64'(axi.ARREADY), 64'd0);
    tick();
    ARESETn = 1'b1;
    #1;
    check("midrst:arready_rel", 64'(axi.ARREADY), 64'd0);
    tick();
    check("midrst:arready_edge", 64'(axi.ARREADY), 64'd1);

    // Normal operation after the abandoned burst
    ea[0] = 16'h0020; ea[1] = 16'h0022;
    run_burst("post_rst", 16'h0020, 8'd1, 3'd1, 2'b01, RESP_OKAY, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
